// File: rtl/mult4u_ppct_pipe.sv
// ---------------------------------------------------------------------------
// mult4u_ppct_pipe
//
// Two-stage 4x4 unsigned multiplier front end. It produces a carry-save pair
// of rows that a downstream 6-bit carry-propagate adder turns into the full
// 8-bit product:
//
//   product = { cout, out_row_a + out_row_b, out_p0 }
//
// Stage S1 captures the operands and the tag. Between S1 and S2, the 16
// partial products are reduced to two rows by a half/full adder tree. Stage
// S2 holds those rows for the consumer.
//
// Both stages use valid/ready handshaking. A stage can load while the stage
// ahead of it drains in the same cycle, so throughput is one operation per
// cycle. Because of this, in_ready depends combinationally on out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of every in-flight operation
//   in_valid   operand pair + tag present
//   in_ready   operand pair accepted this cycle (when in_valid=1, flush=0)
//   in_a/in_b  4-bit unsigned operands
//   in_tag     user tag, carried unchanged to out_tag
//   out_valid  reduced rows present
//   out_ready  downstream consumes the rows this cycle
//   out_p0     product bit 0
//   out_row_a  carry-save row, column weights 2^1..2^6
//   out_row_b  carry-save row, column weights 2^1..2^6
//   out_tag    tag belonging to the rows on the output
// ---------------------------------------------------------------------------
module mult4u_ppct_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_p0,
  output logic [5:0]       out_row_a,
  output logic [5:0]       out_row_b,
  output logic [TAG_W-1:0] out_tag
);

  // Adder cells return {carry, sum}.
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  // ------------------------------------------------------------------
  // Stage registers
  // ------------------------------------------------------------------
  logic             s1_vld_q, s1_vld_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  logic             s2_vld_q, s2_vld_d;
  logic             p0_q, p0_d;
  logic [5:0]       row_a_q, row_a_d;
  logic [5:0]       row_b_q, row_b_d;
  logic [TAG_W-1:0] tag2_q, tag2_d;

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  logic s2_load;
  logic accept;

  // S2 may take new rows when it is empty or is being drained this cycle.
  assign s2_load  = s1_vld_q && (!s2_vld_q || out_ready);
  assign in_ready = !s1_vld_q || s2_load;
  assign accept   = in_valid && in_ready && !flush;

  // ------------------------------------------------------------------
  // Partial products: pp[i][j] = a[j] & b[i], column weight i+j
  // ------------------------------------------------------------------
  logic [3:0][3:0] pp;

  always_comb begin
    pp = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = a_q[j] & b_q[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Reduction tree
  //
  // Column heights for weights 0..6 are 1,2,3,4,3,2,1. The tree works from
  // LSB to MSB and reduces each column, including the carries coming in
  // from the column below, to at most two bits:
  //   w2 : 3      -> HA           -> 2 bits, 1 carry
  //   w3 : 4+1    -> FA + HA      -> 2 bits, 2 carries
  //   w4 : 3+2    -> FA + HA      -> 2 bits, 2 carries
  //   w5 : 2+2    -> FA           -> 2 bits, 1 carry
  //   w6 : 1+1                    -> 2 bits, no carry
  // No carry ever reaches weight 2^7. So row_a + row_b is exactly
  // (a*b) >> 1, and that value is at most 112.
  // ------------------------------------------------------------------
  logic [1:0] h2, f3, h3, f4, h4, f5;
  logic [5:0] red_a, red_b;

  always_comb begin
    red_a = '0;
    red_b = '0;

    // weight 2^1
    red_a[0] = pp[0][1];
    red_b[0] = pp[1][0];

    // weight 2^2
    h2       = ha(pp[0][2], pp[1][1]);
    red_a[1] = h2[0];
    red_b[1] = pp[2][0];

    // weight 2^3
    f3       = fa(pp[0][3], pp[1][2], pp[2][1]);
    h3       = ha(pp[3][0], h2[1]);
    red_a[2] = f3[0];
    red_b[2] = h3[0];

    // weight 2^4
    f4       = fa(pp[1][3], pp[2][2], pp[3][1]);
    h4       = ha(f3[1], h3[1]);
    red_a[3] = f4[0];
    red_b[3] = h4[0];

    // weight 2^5
    f5       = fa(pp[2][3], pp[3][2], f4[1]);
    red_a[4] = f5[0];
    red_b[4] = h4[1];

    // weight 2^6
    red_a[5] = pp[3][3];
    red_b[5] = f5[1];
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    s1_vld_d = s1_vld_q;
    a_d      = a_q;
    b_d      = b_q;
    tag1_d   = tag1_q;

    if (flush) begin
      s1_vld_d = 1'b0;
    end else if (accept) begin
      // Takes priority over draining: a refill keeps S1 valid.
      s1_vld_d = 1'b1;
      a_d      = in_a;
      b_d      = in_b;
      tag1_d   = in_tag;
    end else if (s2_load) begin
      s1_vld_d = 1'b0;
    end
  end

  always_comb begin
    s2_vld_d = s2_vld_q;
    p0_d     = p0_q;
    row_a_d  = row_a_q;
    row_b_d  = row_b_q;
    tag2_d   = tag2_q;

    if (flush) begin
      s2_vld_d = 1'b0;
    end else if (s2_load) begin
      s2_vld_d = 1'b1;
      p0_d     = pp[0][0];
      row_a_d  = red_a;
      row_b_d  = red_b;
      tag2_d   = tag1_q;
    end else if (out_ready) begin
      s2_vld_d = 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      tag1_q   <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag1_q   <= tag1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q <= 1'b0;
      p0_q     <= 1'b0;
      row_a_q  <= '0;
      row_b_q  <= '0;
      tag2_q   <= '0;
    end else begin
      s2_vld_q <= s2_vld_d;
      p0_q     <= p0_d;
      row_a_q  <= row_a_d;
      row_b_q  <= row_b_d;
      tag2_q   <= tag2_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_p0    = p0_q;
  assign out_row_a = row_a_q;
  assign out_row_b = row_b_q;
  assign out_tag   = tag2_q;

endmodule
